lat_mem: RTL

Parametrised single-port word memory for instruction or data use, with configurable access latency and valid/ready handshakes on both the request and response sides. It adds per-byte write enables and out-of-range address detection. It sits between the pipeline's fetch/LSU stage and storage, so the stall behaviour of slower memories can be exercised without changing the core.

---
 rtl/lat_mem.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/lat_mem.sv
// Single-port word memory with a fixed access latency and valid/ready handshakes on both sides.
// Optional per-lane even parity is enabled by defining LAT_MEM_PARITY_EN.
module lat_mem #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 1024,
  parameter int LAT   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_be,
  input  logic            perr_inj,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            rd_perr,
  output logic            busy
);

  localparam int NB = DW / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | latency countdown; access happens when cnt reaches 0
  // RESP  | response presented, waiting for rsp_ready
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            wen_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [NB-1:0]   be_q;
  logic [DW-1:0]   mem [DEPTH];
  logic            in_range;
  logic            access;
  logic [IW-1:0]   idx;
  logic            req_ready_q;

  // Full-width compare: addresses past DEPTH never alias onto real words.
  assign in_range  = ({1'b0, addr_q} < DEPTH_W);
  assign idx       = addr_q[IW-1:0];
  assign access    = (state == WAIT) && (cnt == '0);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign req_ready = req_ready_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = WAIT;
      WAIT:    if (cnt == '0) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready_q <= 1'b1;
      cnt         <= '0;
    end else begin
      state       <= state_nx;
      req_ready_q <= (state_nx == IDLE);
      if (state == IDLE && req_valid)
        cnt <= CW'(LAT - 1);
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && req_valid) begin
      wen_q   <= req_wen;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (access) begin
      rsp_err   <= !in_range;
      rsp_rdata <= (!wen_q && in_range) ? mem[idx] : '0;
    end else if (state == RESP && rsp_ready) begin
      rsp_err   <= 1'b0;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && access && wen_q && in_range) begin
      for (int i = 0; i < NB; i++)
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
    end
  end

`ifdef LAT_MEM_PARITY_EN
  logic            perr_q;
  logic [NB-1:0]   par [DEPTH];
  logic [NB-1:0]   par_calc;
  logic            rd_perr_q;

  assign rd_perr = rd_perr_q;

  always_comb begin
    par_calc = '0;
    for (int i = 0; i < NB; i++)
      par_calc[i] = ^mem[idx][8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && req_valid)
      perr_q <= perr_inj;
  end

  always_ff @(posedge clk) begin
    if (!rst && access && wen_q && in_range) begin
      for (int i = 0; i < NB; i++)
        if (be_q[i]) par[idx][i] <= (^wdata_q[8*i +: 8]) ^ perr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rd_perr_q <= 1'b0;
    else if (access)
      rd_perr_q <= !wen_q && in_range && (par_calc != par[idx]);
    else if (state == RESP && rsp_ready)
      rd_perr_q <= 1'b0;
  end
`else
  logic unused_perr;
  assign unused_perr = perr_inj;
  assign rd_perr     = 1'b0;
`endif

endmodule
